ysyx_25060170_ifu: RTL and testbench
====================================

# ysyx_25060170_ifu

Instruction fetch unit for the NPC core. It owns the architectural PC, fetches one instruction at a time from instruction memory over a valid/ready request/response channel, and presents `{pc, inst}` to the decode stage. It waits for decode to accept the instruction, then waits for the next-PC from writeback before it starts the next fetch. It is the producer end of the `pc_i`/`inst_i`/`ready_o` interface that decode consumes.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: PC loaded at reset.
- `NOP_INST`, default `32'h0000_0013`: value of `inst_o` while no valid instruction is held.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `mem_req_valid_o`  out  1  fetch request valid
- `mem_req_addr_o`  out  32  fetch address, always equal to the PC register
- `mem_req_ready_i`  in  1  memory accepts request
- `mem_resp_valid_i`  in  1  instruction word returned
- `mem_resp_data_i`  in  32  instruction word
- `mem_resp_ready_o`  out  1  IFU accepts response
- `inst_valid_o`  out  1  `inst_o`/`pc_o` hold a fetched instruction
- `pc_o`  out  32  PC of `inst_o`
- `inst_o`  out  32  fetched instruction
- `ready_i`  in  1  decode/execute chain accepts the instruction
- `npc_valid_i`  in  1  writeback presents the next PC
- `npc_i`  in  32  next PC (`pc+4`, branch/jal/jalr target)
- `fetch_cnt_o`  out  32  count of instructions handed to decode

## Operation
- FSM states: IDLE, FETCH, WAIT, ISSUE, COMMIT.
- IDLE: reset state. Moves to FETCH on the first clock edge after `rst` deasserts.
- FETCH: `mem_req_valid_o=1`. Moves to WAIT on `mem_req_ready_i`.
- WAIT: `mem_resp_ready_o=1`. On `mem_resp_valid_i`, `inst_o` captures `mem_resp_data_i` and the FSM moves to ISSUE.
- ISSUE: `inst_valid_o=1`. On `ready_i`, `fetch_cnt_o` increments.
  - If `npc_valid_i` is also high in that cycle, the PC loads `npc_i` and the FSM moves to FETCH. This is the single-cycle commit path.
  - Otherwise the FSM moves to COMMIT.
- COMMIT: `inst_valid_o=0`; `inst_o` and `pc_o` are held. On `npc_valid_i`, the PC loads `npc_i` and the FSM moves to FETCH.
- The PC loads `{npc_i[31:2],2'b00}`. The low bits are discarded and no misalignment fault is raised.
- The following inputs are ignored in every other state:
  - `npc_valid_i` outside ISSUE (with `ready_i`) and COMMIT.
  - `mem_resp_valid_i` outside WAIT.
  - `mem_req_ready_i` outside FETCH.
- `fetch_cnt_o` wraps modulo 2^32.
- `mem_req_valid_o`, `mem_resp_ready_o` and `inst_valid_o` are pure decodes of the state register; no input reaches them combinationally.

## Timing
- Reset values:
  - state IDLE, PC `RESET_PC`, `inst_o` `NOP_INST`, `fetch_cnt_o` 0.
  - `mem_req_valid_o`, `mem_resp_ready_o` and `inst_valid_o` are all 0.
  - `mem_req_addr_o` and `pc_o` both equal `RESET_PC`.
- The first request is visible in the second cycle after reset release (IDLE, then FETCH).
- Best-case latency:
  - Request accepted in cycle N.
  - Response at N+1.
  - `inst_valid_o` at N+2.
  - With the same-cycle `ready_i` and `npc_valid_i`, the next request at N+3.
- Stalls: `mem_req_ready_i` low holds FETCH, with the address stable. `mem_resp_valid_i` low holds WAIT. `ready_i` low holds ISSUE, with outputs stable.
- A response is never accepted in the same cycle as its request.
- Reset asserted in any state immediately forces all reset values. A response still in flight is dropped, because memory shares `rst`.

## Structure
- Shared package `ysyx_25060170_pkg` holds:
  - the FSM state enum (`IFU_IDLE`…`IFU_COMMIT`);
  - `RESET_PC_DEFAULT`;
  - `NOP_INST`;
  - the 32-bit `xlen_t` typedef, which the decode and writeback stages also use.
- No sub-module. The block is a single FSM plus the PC, instruction and counter registers.

## Test plan
- **Reset/first fetch:** hold `rst=0` for 3 cycles, then release.
  - During reset: `mem_req_valid_o=0`, `pc_o=32'h8000_0000`, `inst_o=32'h13`.
  - Second cycle after release: `mem_req_valid_o=1` with address `32'h8000_0000`.
- **Single-cycle commit:** memory always ready, 1-cycle response `32'h00500093`, `ready_i=1`, `npc_valid_i=1`, `npc_i=32'h8000_0004`.
  - `inst_valid_o` is high for exactly 1 cycle.
  - The next request goes to `32'h8000_0004` three cycles after the first request was accepted.
  - `fetch_cnt_o=1`.
- **Memory backpressure:** `mem_req_ready_i` low for 4 cycles, then the response is delayed 3 cycles.
  - The address is stable throughout.
  - `inst_o` updates only on the cycle after `mem_resp_valid_i`.
  - A spurious `mem_resp_valid_i` during FETCH is ignored.
- **Decode stall and late commit:** `ready_i` low for 5 cycles, then high with `npc_valid_i=0`; then `npc_valid_i` high 2 cycles later with `npc_i=32'h8000_0100`.
  - The FSM holds ISSUE and then COMMIT.
  - The next fetch address is `32'h8000_0100`.
- **Jump and alignment:** `npc_i=32'h8000_0013`.
  - The next fetch address is `32'h8000_0010`.
  - `npc_valid_i` pulsed during WAIT has no effect.
- **Reset mid-operation:** assert `rst` in WAIT with a response pending and `fetch_cnt_o=7`.
  - All outputs immediately take their reset values.
  - After release, fetch restarts at `RESET_PC` and the old response is not captured.

Source files
------------

// File: rtl/ysyx_25060170_pkg.sv
// Shared NPC types: machine word, IFU state encoding
// and the reset/bubble constants used across stages.
package ysyx_25060170_pkg;

  typedef logic [31:0] xlen_t;

  localparam xlen_t RESET_PC_DEFAULT = 32'h8000_0000;
  localparam xlen_t NOP_INST         = 32'h0000_0013;

  typedef enum logic [2:0] {
    IFU_IDLE,
    IFU_FETCH,
    IFU_WAIT,
    IFU_ISSUE,
    IFU_COMMIT
  } ifu_state_e;

  // Word-align a target; low bits are dropped silently.
  function automatic xlen_t align_pc(xlen_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_25060170_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word
// at a time, hands it to decode, waits for the next PC.
module ysyx_25060170_ifu
  import ysyx_25060170_pkg::*;
#(
  parameter xlen_t RESET_PC = RESET_PC_DEFAULT,
  parameter xlen_t NOP_INST = ysyx_25060170_pkg::NOP_INST
) (
  input  logic  clk,
  input  logic  rst,
  output logic  mem_req_valid_o,
  output xlen_t mem_req_addr_o,
  input  logic  mem_req_ready_i,
  input  logic  mem_resp_valid_i,
  input  xlen_t mem_resp_data_i,
  output logic  mem_resp_ready_o,
  output logic  inst_valid_o,
  output xlen_t pc_o,
  output xlen_t inst_o,
  input  logic  ready_i,
  input  logic  npc_valid_i,
  input  xlen_t npc_i,
  output xlen_t fetch_cnt_o
);

  ifu_state_e state;
  xlen_t      pc;
  xlen_t      inst_q;
  xlen_t      inst_pc;
  xlen_t      cnt;

  // Fetch sequencing plus PC, instruction and counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IFU_IDLE;
      pc      <= RESET_PC;
      inst_q  <= NOP_INST;
      inst_pc <= RESET_PC;
      cnt     <= '0;
    end else begin
      unique case (state)
        IFU_IDLE: begin
          state <= IFU_FETCH;
        end
        IFU_FETCH: begin
          if (mem_req_ready_i) state <= IFU_WAIT;
        end
        IFU_WAIT: begin
          if (mem_resp_valid_i) begin
            inst_q  <= mem_resp_data_i;
            inst_pc <= pc;
            state   <= IFU_ISSUE;
          end
        end
        IFU_ISSUE: begin
          if (ready_i) begin
            cnt <= cnt + 32'd1;
            if (npc_valid_i) begin
              pc    <= align_pc(npc_i);
              state <= IFU_FETCH;
            end else begin
              state <= IFU_COMMIT;
            end
          end
        end
        IFU_COMMIT: begin
          if (npc_valid_i) begin
            pc    <= align_pc(npc_i);
            state <= IFU_FETCH;
          end
        end
        default: state <= IFU_IDLE;
      endcase
    end
  end

  assign mem_req_valid_o  = (state == IFU_FETCH);
  assign mem_resp_ready_o = (state == IFU_WAIT);
  assign inst_valid_o     = (state == IFU_ISSUE);
  assign mem_req_addr_o   = pc;
  assign pc_o             = inst_pc;
  assign inst_o           = inst_q;
  assign fetch_cnt_o      = cnt;

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// Bench for the IFU: directed scenarios with literal
// expectations plus random traffic against a model.
module tb_ysyx_25060170_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid_o;
  logic [31:0] mem_req_addr_o;
  logic        mem_req_ready_i = 1'b0;
  logic        mem_resp_valid_i = 1'b0;
  logic [31:0] mem_resp_data_i = '0;
  logic        mem_resp_ready_o;
  logic        inst_valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        ready_i = 1'b0;
  logic        npc_valid_i = 1'b0;
  logic [31:0] npc_i = '0;
  logic [31:0] fetch_cnt_o;

  int errors = 0;
  int checks = 0;

  ysyx_25060170_ifu dut (
    .clk              (clk),
    .rst              (rst),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .inst_valid_o     (inst_valid_o),
    .pc_o             (pc_o),
    .inst_o           (inst_o),
    .ready_i          (ready_i),
    .npc_valid_i      (npc_valid_i),
    .npc_i            (npc_i),
    .fetch_cnt_o      (fetch_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // Model: which obligation the unit is currently waiting on.
  // None pending means it has just come out of reset.
  bit          m_req = 0;
  bit          m_resp = 0;
  bit          m_hold = 0;
  bit          m_npc = 0;
  logic [31:0] m_pc = 32'h8000_0000;
  logic [31:0] m_inst = 32'h13;
  logic [31:0] m_ipc = 32'h8000_0000;
  logic [31:0] m_cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_req = 0; m_resp = 0; m_hold = 0; m_npc = 0;
      m_pc = 32'h8000_0000;
      m_inst = 32'h13;
      m_ipc = 32'h8000_0000;
      m_cnt = 0;
    end else if (!(m_req || m_resp || m_hold || m_npc)) begin
      m_req = 1;
    end else if (m_req) begin
      if (mem_req_ready_i) begin
        m_req = 0; m_resp = 1;
      end
    end else if (m_resp) begin
      if (mem_resp_valid_i) begin
        m_resp = 0; m_hold = 1;
        m_inst = mem_resp_data_i;
        m_ipc = m_pc;
      end
    end else if (m_hold) begin
      if (ready_i) begin
        m_hold = 0;
        m_cnt = m_cnt + 1;
        if (npc_valid_i) begin
          m_pc = npc_i & ~32'h3;
          m_req = 1;
        end else begin
          m_npc = 1;
        end
      end
    end else if (npc_valid_i) begin
      m_npc = 0;
      m_pc = npc_i & ~32'h3;
      m_req = 1;
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    chk("req_valid", {31'b0, mem_req_valid_o}, {31'b0, m_req});
    chk("req_addr", mem_req_addr_o, m_pc);
    chk("resp_ready", {31'b0, mem_resp_ready_o}, {31'b0, m_resp});
    chk("inst_valid", {31'b0, inst_valid_o}, {31'b0, m_hold});
    chk("inst", inst_o, m_inst);
    chk("pc", pc_o, m_ipc);
    chk("fetch_cnt", fetch_cnt_o, m_cnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_req_ready_i = 0;
    mem_resp_valid_i = 0;
    ready_i = 0;
    npc_valid_i = 0;
  endtask

  int nv;

  initial begin
    #1 rst = 0;
    repeat (3) step();
    chk("rst_req_valid", {31'b0, mem_req_valid_o}, 0);
    chk("rst_pc", pc_o, 32'h8000_0000);
    chk("rst_inst", inst_o, 32'h13);
    rst = 1;
    chk("idle_no_req", {31'b0, mem_req_valid_o}, 0);
    step();
    chk("first_req", {31'b0, mem_req_valid_o}, 1);
    chk("first_addr", mem_req_addr_o, 32'h8000_0000);

    mem_req_ready_i = 1;
    mem_resp_valid_i = 1;
    mem_resp_data_i = 32'h0050_0093;
    ready_i = 1;
    npc_valid_i = 1;
    npc_i = 32'h8000_0004;
    nv = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      nv += int'(inst_valid_o);
      if (i == 1) chk("fast_inst", inst_o, 32'h0050_0093);
    end
    idle_in();
    chk("fast_valid_cycles", nv, 1);
    chk("fast_next_req", {31'b0, mem_req_valid_o}, 1);
    chk("fast_next_addr", mem_req_addr_o, 32'h8000_0004);
    chk("fast_cnt", fetch_cnt_o, 1);

    mem_resp_valid_i = 1;
    mem_resp_data_i = 32'hdead_beef;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_addr", mem_req_addr_o, 32'h8000_0004);
    end
    mem_resp_valid_i = 0;
    mem_req_ready_i = 1;
    step();
    mem_req_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_inst_old", inst_o, 32'h0050_0093);
    end
    mem_resp_valid_i = 1;
    mem_resp_data_i = 32'h00a0_0113;
    step();
    mem_resp_valid_i = 0;
    chk("bp_inst_new", inst_o, 32'h00a0_0113);
    chk("bp_pc", pc_o, 32'h8000_0004);

    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_issue", {31'b0, inst_valid_o}, 1);
    end
    ready_i = 1;
    step();
    ready_i = 0;
    chk("commit_wait", {31'b0, inst_valid_o}, 0);
    chk("commit_cnt", fetch_cnt_o, 2);
    repeat (2) begin
      step();
      chk("commit_no_req", {31'b0, mem_req_valid_o}, 0);
    end
    npc_valid_i = 1;
    npc_i = 32'h8000_0100;
    step();
    npc_valid_i = 0;
    chk("late_addr", mem_req_addr_o, 32'h8000_0100);

    mem_req_ready_i = 1;
    step();
    mem_req_ready_i = 0;
    npc_valid_i = 1;
    npc_i = 32'h1234_5678;
    repeat (2) step();
    npc_valid_i = 0;
    mem_resp_valid_i = 1;
    mem_resp_data_i = 32'h0000_006f;
    step();
    mem_resp_valid_i = 0;
    chk("wait_npc_ignored", mem_req_addr_o, 32'h8000_0100);
    ready_i = 1;
    npc_valid_i = 1;
    npc_i = 32'h8000_0013;
    step();
    idle_in();
    chk("jump_aligned", mem_req_addr_o, 32'h8000_0010);
    chk("jump_cnt", fetch_cnt_o, 3);

    mem_req_ready_i = 1;
    mem_resp_valid_i = 1;
    ready_i = 1;
    npc_valid_i = 1;
    npc_i = 32'h8000_0020;
    for (int i = 0; i < 40 && fetch_cnt_o != 7; i++) step();
    chk("cnt_seven", fetch_cnt_o, 7);
    idle_in();
    mem_req_ready_i = 1;
    step();
    mem_req_ready_i = 0;
    chk("mid_in_wait", {31'b0, mem_resp_ready_o}, 1);
    mem_resp_valid_i = 1;
    mem_resp_data_i = 32'h0bad_c0de;
    rst = 0;
    #1;
    chk("mid_rst_resp_ready", {31'b0, mem_resp_ready_o}, 0);
    chk("mid_rst_req_valid", {31'b0, mem_req_valid_o}, 0);
    chk("mid_rst_addr", mem_req_addr_o, 32'h8000_0000);
    chk("mid_rst_cnt", fetch_cnt_o, 0);
    chk("mid_rst_inst", inst_o, 32'h13);
    repeat (2) step();
    rst = 1;
    step();
    chk("restart_req", {31'b0, mem_req_valid_o}, 1);
    chk("restart_addr", mem_req_addr_o, 32'h8000_0000);
    chk("old_resp_dropped", inst_o, 32'h13);
    mem_resp_valid_i = 0;

    for (int i = 0; i < 4000; i++) begin
      step();
      rst = ($urandom_range(0, 599) != 0);
      mem_req_ready_i = ($urandom_range(0, 2) != 0);
      mem_resp_valid_i = ($urandom_range(0, 2) != 0);
      mem_resp_data_i = $urandom;
      ready_i = ($urandom_range(0, 3) != 0);
      npc_valid_i = ($urandom_range(0, 2) != 0);
      npc_i = $urandom;
    end
    rst = 1;
    idle_in();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
